// File: rtl/adc_frame_buffer_if.sv
// Sample-stream and read-port bundle for adc_frame_buffer.
// Parameters must match those of the adc_frame_buffer instance.
interface adc_frame_buffer_if #(
  parameter int N_CH  = 8,
  parameter int DEPTH = 256
);
  localparam int FA_W = $clog2(DEPTH / N_CH) + 1;

  logic            Busy;
  logic            write;
  logic [15:0]     toMem;
  logic            rd_en;
  logic [15:0]     rd_data;
  logic [3:0]      rd_chan;
  logic            rd_sof;
  logic            rd_valid;
  logic            empty;
  logic [FA_W-1:0] frames_avail;
  logic [15:0]     drop_cnt;
  logic [15:0]     short_cnt;

  modport master (
    output Busy, write, toMem, rd_en,
    input  rd_data, rd_chan, rd_sof, rd_valid, empty, frames_avail, drop_cnt, short_cnt
  );

  modport slave (
    input  Busy, write, toMem, rd_en,
    output rd_data, rd_chan, rd_sof, rd_valid, empty, frames_avail, drop_cnt, short_cnt
  );
endinterface

// File: rtl/adc_frame_buffer.sv
// Frame-atomic FIFO for the ADC driver sample stream; only complete N_CH-word frames become readable.
// Define ADC_FRAME_BUF_STATS_EN to build the saturating drop_cnt/short_cnt counters (tied to 0 otherwise).
module adc_frame_buffer #(
  parameter int N_CH  = 8,
  parameter int DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  adc_frame_buffer_if.slave bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int FA_W  = $clog2(DEPTH / N_CH) + 1;
  localparam logic [3:0] CNT_LAST = 4'(N_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DROP} state_t;

  state_t             r_state, w_state_nx, w_st;
  logic [PTR_W-1:0]   r_wp, r_sp, r_rp;
  logic [PTR_W-1:0]   w_wp_nx, w_sp_nx, w_sp_b;
  logic [3:0]         r_cnt, w_cnt_nx, w_cnt_b;
  logic               r_busy_q;
  logic               w_sof, w_room, w_we, w_pop;
  logic [PTR_W-1:0]   w_occ, w_frames;
  logic [AW-1:0]      w_waddr;
  logic [15:0]        r_mem [DEPTH];
  logic [15:0]        r_rd_data;
  logic [3:0]         r_rd_chan;
  logic               r_rd_sof, r_rd_valid;

  assign w_sof    = bus.Busy & ~r_busy_q;
  assign w_occ    = r_wp - r_rp;
  assign w_room   = (PTR_W'(DEPTH) - w_occ) >= PTR_W'(N_CH);
  assign w_pop    = bus.rd_en & (w_occ != '0);
  // A frame stays counted until its last word is read, hence round up.
  assign w_frames = (w_occ + PTR_W'(N_CH - 1)) / PTR_W'(N_CH);
  assign w_waddr  = w_sp_b[AW-1:0];

  // Frame start is resolved first so a same-cycle write lands in the new frame.
  always_comb begin
    w_st    = r_state;
    w_sp_b  = r_sp;
    w_cnt_b = r_cnt;
    if (w_sof) begin
      w_sp_b  = r_wp;
      w_cnt_b = '0;
      w_st    = w_room ? S_FILL : S_DROP;
    end
    w_state_nx = w_st;
    w_sp_nx    = w_sp_b;
    w_cnt_nx   = w_cnt_b;
    w_wp_nx    = r_wp;
    w_we       = 1'b0;
    if (bus.write) begin
      case (w_st)
        S_FILL: begin
          w_we     = 1'b1;
          w_sp_nx  = w_sp_b + 1'b1;
          w_cnt_nx = w_cnt_b + 1'b1;
          if (w_cnt_b == CNT_LAST) begin
            w_wp_nx    = w_sp_b + 1'b1;
            w_cnt_nx   = '0;
            w_state_nx = S_IDLE;
          end
        end
        S_DROP: begin
          w_cnt_nx = w_cnt_b + 1'b1;
          if (w_cnt_b == CNT_LAST) begin
            w_cnt_nx   = '0;
            w_state_nx = S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wp       <= '0;
      r_sp       <= '0;
      r_rp       <= '0;
      r_cnt      <= '0;
      r_busy_q   <= 1'b0;
      r_rd_data  <= '0;
      r_rd_chan  <= '0;
      r_rd_sof   <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_wp       <= w_wp_nx;
      r_sp       <= w_sp_nx;
      r_cnt      <= w_cnt_nx;
      r_busy_q   <= bus.Busy;
      r_rd_valid <= w_pop;
      r_rd_sof   <= 1'b0;
      if (w_pop) begin
        r_rp      <= r_rp + 1'b1;
        r_rd_data <= r_mem[r_rp[AW-1:0]];
        r_rd_chan <= 4'(r_rp % PTR_W'(N_CH));
        r_rd_sof  <= (r_rp % PTR_W'(N_CH)) == '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= bus.toMem;
  end

  assign bus.rd_data      = r_rd_data;
  assign bus.rd_chan      = r_rd_chan;
  assign bus.rd_sof       = r_rd_sof;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.empty        = (w_occ == '0);
  assign bus.frames_avail = FA_W'(w_frames);

`ifdef ADC_FRAME_BUF_STATS_EN
  logic        w_drop_inc, w_short_inc;
  logic [15:0] r_drop_cnt, r_short_cnt;

  assign w_drop_inc  = w_sof & ~w_room;
  assign w_short_inc = w_sof & (r_state == S_FILL);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt  <= '0;
      r_short_cnt <= '0;
    end else begin
      if (w_drop_inc && r_drop_cnt != '1)   r_drop_cnt  <= r_drop_cnt + 1'b1;
      if (w_short_inc && r_short_cnt != '1) r_short_cnt <= r_short_cnt + 1'b1;
    end
  end

  assign bus.drop_cnt  = r_drop_cnt;
  assign bus.short_cnt = r_short_cnt;
`else
  assign bus.drop_cnt  = '0;
  assign bus.short_cnt = '0;
`endif
endmodule

// File: tb/tb_adc_frame_buffer.sv
// Directed self-checking bench for adc_frame_buffer (N_CH=8, DEPTH=256).
// Counter expectations follow ADC_FRAME_BUF_STATS_EN.
module tb_adc_frame_buffer;
  localparam int N_CH  = 8;
  localparam int DEPTH = 256;
`ifdef ADC_FRAME_BUF_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adc_frame_buffer_if #(.N_CH(N_CH), .DEPTH(DEPTH)) bus ();

  adc_frame_buffer #(.N_CH(N_CH), .DEPTH(DEPTH)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned conc_cyc = 0;
  bit          drain    = 1'b0;
  logic [31:0] sb_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_start();
    bus.Busy = 1'b1;
    tick();
    bus.Busy = 1'b0;
  endtask

  task automatic put(input logic [15:0] w);
    bus.write = 1'b1;
    bus.toMem = w;
    tick();
    bus.write = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [15:0] d, input int unsigned ch);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check_eq({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
    check_eq({tag, "_data"},  32'(bus.rd_data),  32'(d));
    check_eq({tag, "_chan"},  32'(bus.rd_chan),  32'(ch));
    check_eq({tag, "_sof"},   32'(bus.rd_sof),   (ch == 0) ? 32'd1 : 32'd0);
  endtask

  // Reads every other cycle while streaming, every cycle while draining.
  task automatic tick_collect();
    logic [31:0] exp;
    bus.rd_en = drain | conc_cyc[0];
    tick();
    conc_cyc++;
    if (bus.rd_valid) begin
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
      check_eq("conc_data", 32'(bus.rd_data), exp);
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] single_words [8];
    single_words = '{16'hAAA8, 16'hE38C, 16'hFFFF, 16'hFF8C, 16'hFF80, 16'd3, 16'd4, 16'd5};

    rst       = 1'b1;
    bus.Busy  = 1'b0;
    bus.write = 1'b0;
    bus.toMem = '0;
    bus.rd_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    check_eq("rst_rd_data",  32'(bus.rd_data),      32'd0);
    check_eq("rst_rd_chan",  32'(bus.rd_chan),      32'd0);
    check_eq("rst_rd_sof",   32'(bus.rd_sof),       32'd0);
    check_eq("rst_rd_valid", 32'(bus.rd_valid),     32'd0);
    check_eq("rst_empty",    32'(bus.empty),        32'd1);
    check_eq("rst_frames",   32'(bus.frames_avail), 32'd0);
    check_eq("rst_drop",     32'(bus.drop_cnt),     32'd0);
    check_eq("rst_short",    32'(bus.short_cnt),    32'd0);

    // Stray writes with no Busy rise
    for (int i = 0; i < 4; i++) put(16'h0BAD);
    tick();
    check_eq("stray_empty",  32'(bus.empty),        32'd1);
    check_eq("stray_frames", 32'(bus.frames_avail), 32'd0);

    // Single frame
    frame_start();
    for (int i = 0; i < 7; i++) put(single_words[i]);
    check_eq("single_pre_empty", 32'(bus.empty), 32'd1);
    put(single_words[7]);
    check_eq("single_frames", 32'(bus.frames_avail), 32'd1);
    check_eq("single_empty",  32'(bus.empty),        32'd0);
    for (int i = 0; i < 8; i++) pop_check("single", single_words[i], i);
    check_eq("single_post_empty", 32'(bus.empty), 32'd1);
    tick();
    check_eq("single_idle_valid", 32'(bus.rd_valid), 32'd0);

    // Short frame followed by a complete one
    frame_start();
    for (int i = 0; i < 5; i++) put(16'h0E00 + 16'(i));
    frame_start();
    for (int i = 0; i < 8; i++) put(16'h1000 + 16'(i));
    check_eq("short_cnt",    32'(bus.short_cnt),    STATS ? 32'd1 : 32'd0);
    check_eq("short_frames", 32'(bus.frames_avail), 32'd1);
    for (int i = 0; i < 8; i++) pop_check("short", 16'h1000 + 16'(i), i);
    check_eq("short_empty", 32'(bus.empty), 32'd1);

    // Reset in the middle of a fill
    frame_start();
    for (int i = 0; i < 3; i++) put(16'h0D00 + 16'(i));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mrst_empty",  32'(bus.empty),        32'd1);
    check_eq("mrst_frames", 32'(bus.frames_avail), 32'd0);
    check_eq("mrst_drop",   32'(bus.drop_cnt),     32'd0);
    check_eq("mrst_short",  32'(bus.short_cnt),    32'd0);
    frame_start();
    for (int i = 0; i < 8; i++) put(16'h2000 + 16'(i));
    for (int i = 0; i < 8; i++) pop_check("mrst", 16'h2000 + 16'(i), i);

    // Fill to capacity, then one frame with no room
    for (int f = 0; f < 32; f++) begin
      frame_start();
      for (int i = 0; i < 8; i++) put(16'((f << 8) | i));
    end
    check_eq("full_frames", 32'(bus.frames_avail), 32'd32);
    frame_start();
    for (int i = 0; i < 8; i++) put(16'hFF00 + 16'(i));
    check_eq("full_drop",         32'(bus.drop_cnt),     STATS ? 32'd1 : 32'd0);
    check_eq("full_frames_after", 32'(bus.frames_avail), 32'd32);
    for (int f = 0; f < 32; f++) begin
      for (int i = 0; i < 8; i++) begin
        pop_check("full", 16'((f << 8) | i), i);
        if (f == 0 && i == 0) check_eq("full_partial_frames", 32'(bus.frames_avail), 32'd32);
        if (f == 0 && i == 7) check_eq("full_one_read_frames", 32'(bus.frames_avail), 32'd31);
      end
    end
    check_eq("full_final_empty", 32'(bus.empty), 32'd1);
    tick();
    check_eq("full_no_extra", 32'(bus.rd_valid), 32'd0);

    // Streaming writes with concurrent reads
    for (int f = 0; f < 6; f++) begin
      bus.Busy = 1'b1;
      tick_collect();
      bus.Busy = 1'b0;
      for (int i = 0; i < 8; i++) begin
        bus.write = 1'b1;
        bus.toMem = 16'h5000 + 16'((f << 4) | i);
        sb_q.push_back(32'(bus.toMem));
        tick_collect();
      end
      bus.write = 1'b0;
    end
    drain = 1'b1;
    for (int c = 0; c < 100 && (sb_q.size() > 0 || bus.rd_valid); c++) tick_collect();
    bus.rd_en = 1'b0;
    check_eq("conc_left",  32'(sb_q.size()), 32'd0);
    check_eq("conc_empty", 32'(bus.empty),   32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
